// File: rtl/fxp_add_lanes.sv
// rtl/fxp_add_lanes.sv - multi-lane saturating fixed-point add/sub/accumulate with stall-aware pipeline
module fxp_add_lanes #(
    parameter int LANES     = 4,
    parameter int A_WIDTH   = 16,
    parameter int A_FRAC    = 15,
    parameter int B_WIDTH   = 16,
    parameter int B_FRAC    = 15,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 15,
    parameter int DELAY     = 1,
    parameter int ROUND     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         stall,
    input  logic [1:0]                   mode,
    input  logic [LANES*A_WIDTH-1:0]     a_in,
    input  logic [LANES*B_WIDTH-1:0]     b_in,
    input  logic                         sat_clr,
    output logic [LANES*OUT_WIDTH-1:0]   out,
    output logic                         done,
    output logic [LANES-1:0]             sat,
    output logic [LANES-1:0]             sat_sticky
);

    // Alignment shifts; a positive value is a lossless left shift.
    localparam int SA = OUT_FRAC - A_FRAC;
    localparam int SB = OUT_FRAC - B_FRAC;
    localparam int LA = (SA > 0) ? SA : 0;
    localparam int LB = (SB > 0) ? SB : 0;
    // Internal width holds any aligned operand plus a sum/difference without wrap.
    localparam int EW = OUT_WIDTH + A_WIDTH + B_WIDTH + LA + LB + 4;

    localparam logic signed [EW-1:0] MAXV =
        $signed({{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [EW-1:0] MINV =
        $signed({{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

    // Shift a sign-extended operand to the output fractional position.
    function automatic logic signed [EW-1:0] align(input logic signed [EW-1:0] x,
                                                   input int s);
        logic signed [EW-1:0] half;
        logic signed [EW-1:0] r;
        half = 1;
        if (s >= 0) begin
            r = x <<< s;
        end else if (-s >= EW) begin
            r = {EW{x[EW-1]}};
        end else if (ROUND != 0) begin
            half = half <<< (-s - 1);
            r = (x + half) >>> (-s);
        end else begin
            r = x >>> (-s);
        end
        return r;
    endfunction

    // Index 0 is the stage-1 register (also the accumulator); the last index drives out.
    logic [LANES*OUT_WIDTH-1:0] res_q [DELAY];
    logic [LANES-1:0]           sat_q [DELAY];
    logic [DELAY-1:0]           vld_q;

    logic [LANES*OUT_WIDTH-1:0] n_res;
    logic [LANES-1:0]           n_sat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [A_WIDTH-1:0]   a_l;
        logic [B_WIDTH-1:0]   b_l;
        logic [OUT_WIDTH-1:0] acc_l;
        logic signed [EW-1:0] a_al;
        logic signed [EW-1:0] b_al;
        logic signed [EW-1:0] acc_ext;
        logic signed [EW-1:0] sum;

        assign a_l     = a_in[i*A_WIDTH +: A_WIDTH];
        assign b_l     = b_in[i*B_WIDTH +: B_WIDTH];
        assign acc_l   = res_q[0][i*OUT_WIDTH +: OUT_WIDTH];
        assign a_al    = align($signed({{(EW-A_WIDTH){a_l[A_WIDTH-1]}}, a_l}), SA);
        assign b_al    = align($signed({{(EW-B_WIDTH){b_l[B_WIDTH-1]}}, b_l}), SB);
        assign acc_ext = $signed({{(EW-OUT_WIDTH){acc_l[OUT_WIDTH-1]}}, acc_l});

        // Full-precision lane operation selected by mode.
        always_comb begin
            sum = a_al;
            case (mode)
                2'd0:    sum = a_al + b_al;
                2'd1:    sum = a_al - b_al;
                2'd2:    sum = acc_ext + a_al;
                default: sum = a_al;
            endcase
        end

        assign n_sat[i] = (sum > MAXV) || (sum < MINV);
        assign n_res[i*OUT_WIDTH +: OUT_WIDTH] =
            (sum > MAXV) ? MAXV[OUT_WIDTH-1:0] :
            (sum < MINV) ? MINV[OUT_WIDTH-1:0] : sum[OUT_WIDTH-1:0];
    end

    // Stage-1 load on accepted operands, then a stall-frozen shift through the delay stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DELAY; k++) begin
                res_q[k] <= '0;
                sat_q[k] <= '0;
            end
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= en;
            if (en) begin
                res_q[0] <= n_res;
                sat_q[0] <= n_sat;
            end
            for (int k = 1; k < DELAY; k++) begin
                res_q[k] <= res_q[k-1];
                sat_q[k] <= sat_q[k-1];
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Sticky clamp flags; a same-cycle set beats the clear for that lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_sticky <= '0;
        end else begin
            sat_sticky <= (sat_clr ? '0 : sat_sticky) | ((en && !stall) ? n_sat : '0);
        end
    end

    assign out  = res_q[DELAY-1];
    assign sat  = sat_q[DELAY-1];
    assign done = vld_q[DELAY-1] && !reset;

endmodule

// File: tb/tb_fxp_add_lanes.sv
// tb/tb_fxp_add_lanes.sv - directed self-checking bench for fxp_add_lanes
module tb_fxp_add_lanes;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        stall;
    logic [1:0]  mode;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        sat_clr;

    logic [63:0] out_d1, out_d3, out_r0, out_r1;
    logic        done_d1, done_d3, done_r0, done_r1;
    logic [3:0]  sat_d1, sat_d3, sat_r0, sat_r1;
    logic [3:0]  stk_d1, stk_d3, stk_r0, stk_r1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fxp_add_lanes #(.DELAY(1)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .mode(mode),
        .a_in(a_in), .b_in(b_in), .sat_clr(sat_clr),
        .out(out_d1), .done(done_d1), .sat(sat_d1), .sat_sticky(stk_d1)
    );

    fxp_add_lanes #(.DELAY(3)) u_d3 (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .mode(mode),
        .a_in(a_in), .b_in(b_in), .sat_clr(sat_clr),
        .out(out_d3), .done(done_d3), .sat(sat_d3), .sat_sticky(stk_d3)
    );

    fxp_add_lanes #(.OUT_FRAC(14), .ROUND(0)) u_r0 (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .mode(mode),
        .a_in(a_in), .b_in(b_in), .sat_clr(sat_clr),
        .out(out_r0), .done(done_r0), .sat(sat_r0), .sat_sticky(stk_r0)
    );

    fxp_add_lanes #(.OUT_FRAC(14), .ROUND(1)) u_r1 (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .mode(mode),
        .a_in(a_in), .b_in(b_in), .sat_clr(sat_clr),
        .out(out_r1), .done(done_r1), .sat(sat_r1), .sat_sticky(stk_r1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
        en   = 1'b1;
        mode = m;
        a_in = a;
        b_in = b;
        step();
        en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; stall = 1'b0; mode = 2'd0;
        a_in = '0; b_in = '0; sat_clr = 1'b0;
        step();
        step();
        chk("rst_done_d3", {63'd0, done_d3}, 64'd0);
        reset = 1'b0;
        step();
        chk("rst_out", out_d1, 64'd0);
        chk("rst_sat", {60'd0, sat_d1}, 64'd0);
        chk("rst_stk", {60'd0, stk_d1}, 64'd0);
        chk("rst_done", {63'd0, done_d1}, 64'd0);

        // Add with saturation on lane0, plain add on lane1.
        op(2'd0, 64'h0000_0000_1000_7000, 64'h0000_0000_0800_2000);
        chk("add_out", out_d1, 64'h0000_0000_1800_7FFF);
        chk("add_sat", {60'd0, sat_d1}, 64'h1);
        chk("add_stk", {60'd0, stk_d1}, 64'h1);
        chk("add_done", {63'd0, done_d1}, 64'd1);
        step();
        chk("add_done_drop", {63'd0, done_d1}, 64'd0);
        chk("add_hold", out_d1, 64'h0000_0000_1800_7FFF);

        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("clr_stk", {60'd0, stk_d1}, 64'h0);

        // Subtract at both rails.
        op(2'd1, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001);
        chk("sub_neg_out", out_d1, 64'h0000_0000_0000_8000);
        chk("sub_neg_sat", {60'd0, sat_d1}, 64'h1);
        op(2'd1, 64'h0, 64'h0000_0000_0000_8000);
        chk("sub_pos_out", out_d1, 64'h0000_0000_0000_7FFF);
        chk("sub_pos_sat", {60'd0, sat_d1}, 64'h1);

        // Accumulate chain with saturation hold.
        op(2'd3, 64'h1000, 64'hFFFF);
        chk("acc_load", out_d1, 64'h1000);
        chk("acc_load_sat", {60'd0, sat_d1}, 64'h0);
        op(2'd2, 64'h1000, 64'hFFFF);
        chk("acc_1", out_d1, 64'h2000);
        op(2'd2, 64'h1000, 64'hFFFF);
        chk("acc_2", out_d1, 64'h3000);
        op(2'd2, 64'h1000, 64'hFFFF);
        chk("acc_3", out_d1, 64'h4000);
        op(2'd2, 64'h4000, 64'h0);
        chk("acc_sat", out_d1, 64'h7FFF);
        chk("acc_sat_flag", {60'd0, sat_d1}, 64'h1);
        op(2'd2, 64'h4000, 64'h0);
        chk("acc_stay", out_d1, 64'h7FFF);

        // Flush the DELAY=3 pipe, then stall in the cycle after en.
        step(); step(); step();
        chk("d3_pre", out_d3[15:0], 64'h7FFF);
        op(2'd3, 64'h0123, 64'h0);
        chk("stl_k0_done", {63'd0, done_d3}, 64'd0);
        stall = 1'b1;
        op(2'd3, 64'h0456, 64'h0);
        stall = 1'b0;
        chk("stl_k1_done", {63'd0, done_d3}, 64'd0);
        chk("stl_k1_hold", out_d3, 64'h7FFF);
        step();
        chk("stl_k2_done", {63'd0, done_d3}, 64'd0);
        step();
        chk("stl_k3_done", {63'd0, done_d3}, 64'd1);
        chk("stl_k3_out", out_d3, 64'h0123);
        step();
        chk("stl_k4_done", {63'd0, done_d3}, 64'd0);
        step();
        chk("stl_k5_done", {63'd0, done_d3}, 64'd0);
        chk("stl_k5_out", out_d3, 64'h0123);

        // Rounding on a one-bit right alignment.
        op(2'd3, 64'h0000_0000_FFFD_0003, 64'h0);
        chk("rnd0_pos", {48'd0, out_r0[15:0]}, 64'h0001);
        chk("rnd0_neg", {48'd0, out_r0[31:16]}, 64'hFFFE);
        chk("rnd1_pos", {48'd0, out_r1[15:0]}, 64'h0002);
        chk("rnd1_neg", {48'd0, out_r1[31:16]}, 64'hFFFF);

        // Reset with two results in flight.
        op(2'd3, 64'h0100, 64'h0);
        op(2'd3, 64'h0200, 64'h0);
        reset = 1'b1;
        step();
        chk("rst_mid_out", out_d3, 64'd0);
        chk("rst_mid_sat", {60'd0, sat_d3}, 64'd0);
        chk("rst_mid_stk", {60'd0, stk_d3}, 64'd0);
        chk("rst_mid_done", {63'd0, done_d3}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_flight_done", {63'd0, done_d3}, 64'd0);
        end

        // Sticky set beats clear on the same lane.
        op(2'd0, 64'h0000_0000_7000_0000, 64'h0000_0000_2000_0000);
        chk("stk_lane1", {60'd0, stk_d1}, 64'h2);
        sat_clr = 1'b1;
        op(2'd0, 64'h7000, 64'h2000);
        sat_clr = 1'b0;
        chk("stk_prio", {60'd0, stk_d1}, 64'h1);
        chk("stk_prio_sat", {60'd0, sat_d1}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
